// File: rtl/pll_lock_sequencer.sv
// PLL power-up / relock sequencer: holds the PLL in reset, waits for a stable lock with
// timeout and bounded retries, then releases the downstream synchronous reset.
module pll_lock_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       pll_locked_in,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] retry_cnt,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HOLD      = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sync1;
  logic             r_sync2;
  logic [7:0]       r_retry;
  logic [7:0]       r_loss;
  logic             r_pll_rst;
  logic             r_sys_rst_n;
  logic             r_ready;
  logic             r_fault;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       w_retry_nxt;
  logic [7:0]       w_loss_nxt;
  logic             w_locked;
  logic             w_pll_rst_nxt;
  logic             w_sys_rst_n_nxt;
  logic             w_ready_nxt;
  logic             w_fault_nxt;

  assign w_locked = r_sync2;

  // Next-state logic; en=0 overrides every other transition, lock loss included.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    w_loss_nxt  = r_loss;
    if (!en) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_retry_nxt = 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
          w_retry_nxt = 8'd0;
        end
        ST_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (w_locked) begin
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == TIMEOUT_LAST) begin
            w_cnt_nxt = '0;
            if (r_retry == RETRY_LIMIT) begin
              w_state_nxt = ST_FAULT;
            end else begin
              w_state_nxt = ST_HOLD;
              w_retry_nxt = r_retry + 8'd1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          // A dropout restarts the lock wait without consuming a retry.
          if (!w_locked) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else if (r_cnt == STABLE_LAST) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!w_locked) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
            w_retry_nxt = 8'd0;
            w_loss_nxt  = (r_loss == 8'hFF) ? r_loss : (r_loss + 8'd1);
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_retry_nxt = 8'd0;
        end
      endcase
    end
  end

  // Moore output decode from the next state so outputs flop on the same edge as the state.
  always_comb begin
    w_pll_rst_nxt   = 1'b1;
    w_sys_rst_n_nxt = 1'b0;
    w_ready_nxt     = 1'b0;
    w_fault_nxt     = 1'b0;
    case (w_state_nxt)
      ST_IDLE:      w_pll_rst_nxt = 1'b1;
      ST_HOLD:      w_pll_rst_nxt = 1'b1;
      ST_WAIT_LOCK: w_pll_rst_nxt = 1'b0;
      ST_STABLE:    w_pll_rst_nxt = 1'b0;
      ST_RUN: begin
        w_pll_rst_nxt   = 1'b0;
        w_sys_rst_n_nxt = 1'b1;
        w_ready_nxt     = 1'b1;
      end
      ST_FAULT: begin
        w_pll_rst_nxt = 1'b1;
        w_fault_nxt   = 1'b1;
      end
      default:      w_pll_rst_nxt = 1'b1;
    endcase
  end

  // State, counters, lock synchroniser and registered outputs.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_retry     <= 8'd0;
      r_loss      <= 8'd0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sync1     <= pll_locked_in;
      r_sync2     <= r_sync1;
      r_retry     <= w_retry_nxt;
      r_loss      <= w_loss_nxt;
      r_pll_rst   <= w_pll_rst_nxt;
      r_sys_rst_n <= w_sys_rst_n_nxt;
      r_ready     <= w_ready_nxt;
      r_fault     <= w_fault_nxt;
    end
  end

  assign pll_rst       = r_pll_rst;
  assign sys_rst_n     = r_sys_rst_n;
  assign ready         = r_ready;
  assign fault         = r_fault;
  assign retry_cnt     = r_retry;
  assign lock_loss_cnt = r_loss;
  assign state_o       = r_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench: stimulus schedules expected output snapshots keyed by edge number,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pll_lock_sequencer;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HOLD   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_STABLE = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       pll_locked_in = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [7:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state_o;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit done = 1'b0;

  typedef struct {
    int          cyc;
    string       name;
    logic [22:0] vec;
  } exp_t;

  exp_t sb_q[$];

  pll_lock_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES(2),
    .CNT_W(16)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .en(en),
    .pll_locked_in(pll_locked_in),
    .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n),
    .ready(ready),
    .fault(fault),
    .retry_cnt(retry_cnt),
    .lock_loss_cnt(lock_loss_cnt),
    .state_o(state_o)
  );

  always #5 refclk = ~refclk;

  // Edge counter: after posedge N, cyc == N.
  always @(posedge refclk) cyc <= cyc + 1;

  function automatic logic [22:0] pack_exp(input logic [2:0] st, input logic pr, input logic sr,
                                           input logic rd, input logic ft,
                                           input logic [7:0] rc, input logic [7:0] lc);
    return {st, pr, sr, rd, ft, rc, lc};
  endfunction

  task automatic expect_at(input int c, input string nm, input logic [2:0] st, input logic pr,
                           input logic sr, input logic rd, input logic ft,
                           input logic [7:0] rc, input logic [7:0] lc);
    exp_t e;
    e.cyc  = c;
    e.name = nm;
    e.vec  = pack_exp(st, pr, sr, rd, ft, rc, lc);
    sb_q.push_back(e);
  endtask

  task automatic expect_rst(input int c, input string nm);
    expect_at(c, nm, S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge refclk);
      #1;
    end
  endtask

  // Monitor: compares every snapshot scheduled for the current edge.
  initial begin : monitor
    exp_t        e;
    logic [22:0] act;
    forever begin
      @(negedge refclk);
      act = pack_exp(state_o, pll_rst, sys_rst_n, ready, fault, retry_cnt, lock_loss_cnt);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        n_checks++;
        if (e.cyc != cyc) begin
          n_fail++;
          $display("FAIL %s: not sampled at edge %0d (now %0d)", e.name, e.cyc, cyc);
        end else if (act !== e.vec) begin
          n_fail++;
          $display("FAIL %s @edge %0d: got st=%0d prst=%b srn=%b rdy=%b flt=%b retry=%0d loss=%0d, want st=%0d prst=%b srn=%b rdy=%b flt=%b retry=%0d loss=%0d",
                   e.name, cyc, act[22:20], act[19], act[18], act[17], act[16], act[15:8], act[7:0],
                   e.vec[22:20], e.vec[19], e.vec[18], e.vec[17], e.vec[16], e.vec[15:8], e.vec[7:0]);
        end
      end
    end
  end

  initial begin : stimulus
    // Reset for two edges.
    wait_to(2);
    expect_rst(2, "reset_state");
    rst_n = 1'b1;
    en    = 1'b1;

    // Nominal: HOLD 3..6, WAIT from 7, lock raised after edge 7, RUN at 18.
    expect_at(3,  "hold_enter",  S_HOLD,   1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    expect_at(6,  "hold_last",   S_HOLD,   1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    expect_at(7,  "wait_enter",  S_WAIT,   1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    wait_to(7);
    pll_locked_in = 1'b1;
    expect_at(10, "stable_enter", S_STABLE, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    expect_at(17, "stable_last",  S_STABLE, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    expect_at(18, "run_enter",    S_RUN,    1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);

    // Lock loss in RUN: ready drops at 23, HOLD 23..26, WAIT at 27.
    wait_to(20);
    pll_locked_in = 1'b0;
    expect_at(22, "loss_still_run", S_RUN,  1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
    expect_at(23, "loss_hold",      S_HOLD, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1);
    expect_at(26, "loss_hold_last", S_HOLD, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1);
    expect_at(27, "loss_wait",      S_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1);

    // Relock with a one-cycle dropout during STABLE (STABLE entered at 30).
    wait_to(27);
    pll_locked_in = 1'b1;
    wait_to(34);
    pll_locked_in = 1'b0;
    wait_to(35);
    pll_locked_in = 1'b1;
    expect_at(36, "glitch_pre",    S_STABLE, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1);
    expect_at(37, "glitch_wait",   S_WAIT,   1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1);
    expect_at(38, "glitch_stable", S_STABLE, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1);
    expect_at(45, "glitch_no_rdy", S_STABLE, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1);
    expect_at(46, "glitch_run",    S_RUN,    1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1);

    // Priority: en=0 on the edge that would see the lock loss.
    wait_to(50);
    pll_locked_in = 1'b0;
    expect_at(52, "prio_run",  S_RUN,  1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1);
    expect_at(53, "prio_idle", S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1);
    wait_to(52);
    en = 1'b0;

    // Timeout and fault: three attempts of 24 cycles each, FAULT at 129.
    wait_to(56);
    en = 1'b1;
    expect_at(57,  "to_hold0",  S_HOLD,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1);
    expect_at(80,  "to_wait0",  S_WAIT,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1);
    expect_at(81,  "to_hold1",  S_HOLD,  1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
    expect_at(104, "to_wait1",  S_WAIT,  1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
    expect_at(105, "to_hold2",  S_HOLD,  1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 8'd1);
    expect_at(128, "to_wait2",  S_WAIT,  1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd1);
    expect_at(129, "to_fault",  S_FAULT, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 8'd1);
    wait_to(131);
    en = 1'b0;
    expect_at(132, "fault_exit", S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1);

    // Reset during STABLE (STABLE entered at 143).
    wait_to(135);
    en = 1'b1;
    wait_to(140);
    pll_locked_in = 1'b1;
    expect_at(145, "pre_rst_stable", S_STABLE, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1);
    wait_to(145);
    rst_n = 1'b0;
    expect_rst(146, "rst_in_stable");

    // Reset during FAULT.
    wait_to(147);
    rst_n = 1'b1;
    pll_locked_in = 1'b0;
    expect_at(148, "f2_hold",  S_HOLD,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    expect_at(220, "f2_fault", S_FAULT, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 8'd0);
    expect_at(222, "f2_stay",  S_FAULT, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 8'd0);
    wait_to(222);
    rst_n = 1'b0;
    expect_rst(223, "rst_in_fault");
    wait_to(225);
    rst_n = 1'b1;
    en    = 1'b0;
    expect_rst(227, "idle_after");

    wait_to(232);
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: scheduled for edge %0d never compared", e.name, e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
